// File: rtl/alu_operand_sequencer.sv
// Serial operand/opcode capture stage feeding the ALU: collects A, B and opcode on strobe
// edges, holds alu_go for EXEC_CYCLES, then latches and holds the ALU result and flags.
module alu_operand_sequencer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [DATA_W-1:0] din,
    input  logic              strb,
    input  logic              clr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_go,
    input  logic [DATA_W-1:0] alu_y,
    input  logic [3:0]        alu_flags,
    output logic [DATA_W-1:0] res,
    output logic [3:0]        res_flags,
    output logic              res_valid,
    output logic              busy
);

    localparam int unsigned     CNT_W   = $clog2(EXEC_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitB,
        StWaitOp,
        StExec,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              strb_q;
    logic              strb_edge;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        flags_q, flags_d;
    logic              valid_q, valid_d;
    logic              go_q, go_d;

    assign strb_edge = strb & ~strb_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        valid_d = valid_q;

        // Nothing advances while disabled; an edge seen now is simply lost.
        if (ena) begin
            if (clr) begin
                state_d = StIdle;
                valid_d = 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (strb_edge) begin
                            a_d     = din;
                            valid_d = 1'b0;
                            state_d = StWaitB;
                        end
                    end
                    StWaitB: begin
                        if (strb_edge) begin
                            b_d     = din;
                            state_d = StWaitOp;
                        end
                    end
                    StWaitOp: begin
                        if (strb_edge) begin
                            op_d    = din[OP_W-1:0];
                            cnt_d   = '0;
                            state_d = StExec;
                        end
                    end
                    StExec: begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CntLast) begin
                            res_d   = alu_y;
                            flags_d = alu_flags;
                            valid_d = 1'b1;
                            state_d = StDone;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        // Registered decode so alu_go is high exactly while in StExec.
        go_d = (state_d == StExec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            strb_q  <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            strb_q  <= strb;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
            go_q    <= go_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_go    = go_q;
    assign res       = res_q;
    assign res_flags = flags_q;
    assign res_valid = valid_q;
    assign busy      = (state_q == StWaitB) || (state_q == StWaitOp) || (state_q == StExec);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: one instance with EXEC_CYCLES=1 and one with
// EXEC_CYCLES=3 share stimulus; results are scoreboarded against queued expectations.
module tb_alu_operand_sequencer;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       strb;
    logic       clr;
    logic [7:0] din;

    logic [7:0] a1, b1, y1, res1;
    logic [3:0] op1, fl1, rfl1;
    logic       go1, rv1, busy1;

    logic [7:0] a3, b3, y3, res3;
    logic [3:0] op3, fl3, rfl3;
    logic       go3, rv3, busy3;

    int checks   = 0;
    int failures = 0;

    logic [11:0] q1[$];
    logic [11:0] q3[$];

    // ALU stand-in: 1 = add, 2 = sub, others = xor; returns {C,Z,N,V,y}.
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] op);
        logic [8:0] s;
        logic       v;
        case (op)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[7] == b[7]) && (s[7] != a[7]);
            end
            4'd2: begin
                s = {1'b0, a} - {1'b0, b};
                v = (a[7] != b[7]) && (s[7] != a[7]);
            end
            default: begin
                s = {1'b0, a ^ b};
                v = 1'b0;
            end
        endcase
        return {s[8], (s[7:0] == 8'h00), s[7], v, s[7:0]};
    endfunction

    assign {fl1, y1} = alu_model(a1, b1, op1);
    assign {fl3, y3} = alu_model(a3, b3, op3);

    alu_operand_sequencer #(.DATA_W(8), .OP_W(4), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .strb(strb), .clr(clr),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_go(go1),
        .alu_y(y1), .alu_flags(fl1),
        .res(res1), .res_flags(rfl1), .res_valid(rv1), .busy(busy1)
    );

    alu_operand_sequencer #(.DATA_W(8), .OP_W(4), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .strb(strb), .clr(clr),
        .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_go(go3),
        .alu_y(y3), .alu_flags(fl3),
        .res(res3), .res_flags(rfl3), .res_valid(rv3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each rising res_valid consumes one queued expectation.
    logic rv1_prev = 1'b0;
    logic rv3_prev = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (rv1 && !rv1_prev) begin
            if (q1.size() == 0) check("sb1_unexpected", 32'd1, 32'd0);
            else check("sb1_result", {20'd0, rfl1, res1}, {20'd0, q1.pop_front()});
        end
        if (rv3 && !rv3_prev) begin
            if (q3.size() == 0) check("sb3_unexpected", 32'd1, 32'd0);
            else check("sb3_result", {20'd0, rfl3, res3}, {20'd0, q3.pop_front()});
        end
        rv1_prev = rv1;
        rv3_prev = rv3;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    logic ena_pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic strb_pat [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   go_cnt;

    initial begin
        rst  = 1'b1;
        ena  = 1'b1;
        strb = 1'b0;
        clr  = 1'b0;
        din  = 8'h00;

        // Reset with strobe toggling: nothing may be captured.
        din = 8'h55;
        for (int i = 0; i < 4; i++) begin
            strb = ~strb;
            tick();
        end
        check("rst_a_during", a1, 8'h00);
        rst = 1'b0;
        tick();
        check("rst_a", a1, 8'h00);
        check("rst_b", b1, 8'h00);
        check("rst_op", op1, 4'h0);
        check("rst_go", go1, 1'b0);
        check("rst_res", res1, 8'h00);
        check("rst_flags", rfl1, 4'h0);
        check("rst_valid", rv1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_busy3", busy3, 1'b0);

        // Full load: A=0x12, B=0x34, op=ADD.
        din = 8'h12; strb = 1'b1; tick();
        check("load_a", a1, 8'h12);
        check("busy_wait_b", busy1, 1'b1);
        strb = 1'b0; tick();
        din = 8'h34; strb = 1'b1; tick();
        check("load_b", b1, 8'h34);
        strb = 1'b0; tick();
        din = 8'h01; strb = 1'b1;
        q1.push_back(12'h046);
        q3.push_back(12'h046);
        tick();
        check("load_op", op1, 4'h1);
        check("exec_go", go1, 1'b1);
        check("exec_valid", rv1, 1'b0);
        strb = 1'b0; tick();
        check("done_go", go1, 1'b0);
        check("done_valid", rv1, 1'b1);
        check("done_res", res1, 8'h46);
        check("done_busy", busy1, 1'b0);
        check("done_a_stable", a1, 8'h12);
        repeat (3) tick();
        check("done3_valid", rv3, 1'b1);
        check("done3_res", res3, 8'h46);

        // New load from DONE: valid drops, result retained.
        din = 8'h07; strb = 1'b1; tick();
        check("reload_valid", rv1, 1'b0);
        check("reload_a", a1, 8'h07);
        check("reload_res", res1, 8'h46);
        check("reload_busy", busy1, 1'b1);
        strb = 1'b0; tick();

        // Abort to IDLE, then a long strobe counts as one edge.
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_busy", busy1, 1'b0);
        check("clr_a_kept", a1, 8'h07);
        din = 8'hAA; strb = 1'b1;
        repeat (10) tick();
        check("held_a", a1, 8'hAA);
        check("held_b", b1, 8'h34);
        check("held_busy", busy1, 1'b1);
        strb = 1'b0; tick();
        din = 8'h56; strb = 1'b1; tick();
        check("held_then_b", b1, 8'h56);
        strb = 1'b0; tick();

        // clr beats a simultaneous opcode edge.
        din = 8'h02; strb = 1'b1; clr = 1'b1; tick();
        check("clr_edge_busy", busy1, 1'b0);
        check("clr_edge_valid", rv1, 1'b0);
        check("clr_edge_op", op1, 4'h1);
        check("clr_edge_go", go1, 1'b0);
        clr = 1'b0; strb = 1'b0; tick();
        check("clr_edge_idle", busy1, 1'b0);

        // EXEC_CYCLES=3 with ena dropped for two cycles mid-EXEC.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        din = 8'h50; strb = 1'b1; tick(); strb = 1'b0; tick();
        din = 8'h20; strb = 1'b1; tick(); strb = 1'b0; tick();
        din = 8'h02; strb = 1'b1;
        q1.push_back(12'h030);
        q3.push_back(12'h030);
        tick();
        din = 8'hEE;
        go_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            check("exec3_go", go3, 1'b1);
            check("exec3_valid", rv3, 1'b0);
            if (go3) go_cnt++;
            ena  = ena_pat[i];
            strb = strb_pat[i];
            tick();
        end
        check("exec3_go_cycles", go_cnt, 5);
        check("exec3_go_end", go3, 1'b0);
        check("exec3_done", rv3, 1'b1);
        check("exec3_res", res3, 8'h30);
        check("exec3_a_kept", a3, 8'h50);

        tick();
        check("sb1_drained", q1.size(), 0);
        check("sb3_drained", q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
